// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and issue: a circular queue that accepts up to two
// instructions per cycle and presents the two oldest for single- or dual-issue.
module instr_buffer #(
  parameter int DEPTH = 8,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [IW-1:0] in_instr1,
  input  logic [IW-1:0] in_instr2,
  input  logic [1:0]    in_count,
  output logic          stall,
  input  logic          issue_ready,
  output logic [IW-1:0] out_instr1,
  output logic [IW-1:0] out_instr2,
  output logic          out_valid1,
  output logic          out_valid2,
  output logic          issingleinstr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] push_n, pop_n;
  logic [PW-1:0] head_p1, tail_p1;
  logic          hazard;
  logic          wr1, wr2;

  assign head_p1 = head_q + 1'b1;
  assign tail_p1 = tail_q + 1'b1;

  // Stall from registered occupancy only, so fetch sees a glitch-free signal.
  assign stall = (count_q >= CW'(DEPTH - 1));

  assign out_instr1 = mem_q[head_q];
  assign out_instr2 = mem_q[head_p1];

  // Younger entry reads the older one's destination, or the older one is branch class.
  assign hazard = (out_instr2[8:6] == out_instr1[11:9]) ||
                  (out_instr2[5:3] == out_instr1[11:9]) ||
                  (out_instr1[15:14] == 2'b11);

  assign out_valid1    = (count_q >= CW'(1));
  assign out_valid2    = (count_q >= CW'(2)) && !hazard;
  assign issingleinstr = out_valid1 && !out_valid2;

  always_comb begin
    push_n = '0;
    if (!stall && !flush) begin
      case (in_count)
        2'd0:    push_n = CW'(0);
        2'd1:    push_n = CW'(1);
        default: push_n = CW'(2);
      endcase
    end
    pop_n = '0;
    if (issue_ready) pop_n = CW'(out_valid1) + CW'(out_valid2);
    wr1 = (push_n != '0);
    wr2 = (push_n == CW'(2));
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_n);
      tail_d  = tail_q + PW'(push_n);
      count_d = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is data only and is never reset; writes land in slots outside the live window.
  always_ff @(posedge clk) begin
    if (wr1) mem_q[tail_q]  <= in_instr1;
    if (wr2) mem_q[tail_p1] <= in_instr2;
  end
endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_instr_buffer;
  localparam int DEPTH = 8;
  localparam int IW    = 16;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [IW-1:0] in_instr1, in_instr2;
  logic [1:0]    in_count;
  logic          stall;
  logic          issue_ready;
  logic [IW-1:0] out_instr1, out_instr2;
  logic          out_valid1, out_valid2, issingleinstr;

  instr_buffer #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_instr1(in_instr1), .in_instr2(in_instr2), .in_count(in_count),
    .stall(stall), .issue_ready(issue_ready),
    .out_instr1(out_instr1), .out_instr2(out_instr2),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .issingleinstr(issingleinstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IW-1:0] q[$];
  logic [IW-1:0] issued[$];
  logic [IW-1:0] fed[$];
  bit            rec = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit pair_hazard(input int older, input int younger);
    int rd, rs1, rs2, opc;
    rd  = (older / 512) % 8;
    opc = (older / 4096) % 16;
    rs1 = (younger / 64) % 8;
    rs2 = (younger / 8) % 8;
    return (rs1 == rd) || (rs2 == rd) || (opc >= 12);
  endfunction

  function automatic bit model_v2();
    if (q.size() < 2) return 1'b0;
    return !pair_hazard(int'(q[0]), int'(q[1]));
  endfunction

  task automatic compare_all();
    int  sz;
    bit  v1, v2;
    sz = q.size();
    v1 = (sz >= 1);
    v2 = model_v2();
    check_eq("stall", 32'(stall), 32'((DEPTH - sz) < 2));
    check_eq("valid1", 32'(out_valid1), 32'(v1));
    check_eq("valid2", 32'(out_valid2), 32'(v2));
    check_eq("single", 32'(issingleinstr), 32'(v1 && !v2));
    if (v1) check_eq("instr1", 32'(out_instr1), 32'(q[0]));
    if (sz >= 2) check_eq("instr2", 32'(out_instr2), 32'(q[1]));
  endtask

  task automatic model_edge(input bit fl, input logic [1:0] cnt, input logic [IW-1:0] a,
                            input logic [IW-1:0] b, input bit rdy, output int acc);
    bit st, v1, v2;
    int n;
    acc = 0;
    st = (DEPTH - q.size()) < 2;
    v1 = (q.size() >= 1);
    v2 = model_v2();
    if (fl) begin
      q.delete();
    end else begin
      if (rdy && v1) void'(q.pop_front());
      if (rdy && v2) void'(q.pop_front());
      if (!st) begin
        n = (cnt == 2'd0) ? 0 : (cnt == 2'd1) ? 1 : 2;
        if (n >= 1) q.push_back(a);
        if (n == 2) q.push_back(b);
        acc = n;
      end
    end
  endtask

  // Called at a falling edge: drive, take the rising edge, then check at the next falling edge.
  task automatic cycle(input bit fl, input logic [1:0] cnt, input logic [IW-1:0] a,
                       input logic [IW-1:0] b, input bit rdy, output int acc);
    flush = fl; in_count = cnt; in_instr1 = a; in_instr2 = b; issue_ready = rdy;
    #1;
    if (rec && rdy && out_valid1) issued.push_back(out_instr1);
    if (rec && rdy && out_valid2) issued.push_back(out_instr2);
    @(posedge clk);
    model_edge(fl, cnt, a, b, rdy, acc);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int acc;
    int k;
    logic [1:0] c;
    flush = 0; in_count = 0; in_instr1 = 0; in_instr2 = 0; issue_ready = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    compare_all();
    check_eq("rst_valid1", 32'(out_valid1), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // Basic dual push, no hazard
    cycle(0, 2'd2, 16'h1234, 16'h2345, 0, acc);
    check_eq("dual_v2", 32'(out_valid2), 32'd1);
    check_eq("dual_i1", 32'(out_instr1), 32'h1234);
    check_eq("dual_i2", 32'(out_instr2), 32'h2345);
    check_eq("dual_single", 32'(issingleinstr), 32'd0);
    cycle(1, 2'd0, 16'h0, 16'h0, 0, acc);

    // RAW hazard pair issues one at a time
    cycle(0, 2'd2, 16'h1200, 16'h2040, 0, acc);
    check_eq("haz_single", 32'(issingleinstr), 32'd1);
    cycle(0, 2'd0, 16'h0, 16'h0, 1, acc);
    check_eq("haz_next_i1", 32'(out_instr1), 32'h2040);
    check_eq("haz_next_v2", 32'(out_valid2), 32'd0);
    cycle(1, 2'd0, 16'h0, 16'h0, 0, acc);

    // Fill with branch-class entries to 7, extra input ignored, single pop releases stall
    for (int i = 0; i < 7; i++) cycle(0, 2'd1, 16'hC000 | 16'(i), 16'hFFFF, 0, acc);
    check_eq("full7_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 2; i++) cycle(0, 2'd2, 16'h5555, 16'h6666, 0, acc);
    check_eq("full7_hold", 32'(stall), 32'd1);
    cycle(0, 2'd0, 16'h0, 16'h0, 1, acc);
    check_eq("pop1_stall", 32'(stall), 32'd0);
    check_eq("pop1_i1", 32'(out_instr1), 32'hC001);
    cycle(1, 2'd0, 16'h0, 16'h0, 0, acc);

    // Flush wins over a coincident push and pop
    cycle(0, 2'd2, 16'h0111, 16'h0222, 0, acc);
    cycle(0, 2'd2, 16'h0333, 16'h0444, 0, acc);
    cycle(0, 2'd1, 16'h0555, 16'h0666, 0, acc);
    cycle(1, 2'd2, 16'h0777, 16'h0888, 1, acc);
    check_eq("flush_v1", 32'(out_valid1), 32'd0);
    check_eq("flush_stall", 32'(stall), 32'd0);

    // Wrap-around ordering over 20 instructions
    issued.delete(); fed.delete();
    for (int i = 0; i < 20; i++) fed.push_back(16'($urandom_range(0, 65535)));
    rec = 1'b1;
    k = 0;
    for (int t = 0; t < 200 && k < 20; t++) begin
      c = 2'($urandom_range(0, 2));
      if (k == 19 && c == 2'd2) c = 2'd1;
      cycle(0, c, fed[k], (k < 19) ? fed[k+1] : 16'h0, bit'($urandom_range(0, 1)), acc);
      k += acc;
    end
    check_eq("wrap_all_fed", 32'(k), 32'd20);
    for (int t = 0; t < 40 && q.size() > 0; t++) cycle(0, 2'd0, 16'h0, 16'h0, 1, acc);
    rec = 1'b0;
    check_eq("wrap_len", 32'(issued.size()), 32'd20);
    for (int i = 0; i < 20 && i < issued.size(); i++) check_eq("wrap_order", 32'(issued[i]), 32'(fed[i]));

    // Asynchronous reset mid-cycle with four entries
    cycle(0, 2'd2, 16'h0A01, 16'h0A02, 0, acc);
    cycle(0, 2'd2, 16'h0A03, 16'h0A04, 0, acc);
    #2 reset = 1'b1;
    #1 check_eq("async_rst_v1", 32'(out_valid1), 32'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    cycle(0, 2'd1, 16'h0B0B, 16'h0, 0, acc);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      cycle(bit'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
            16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            bit'($urandom_range(0, 1)), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_buffer.md
INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entries; must be a power of two and at least 4.
REQ-002 SHALL have parameter IW, default 16, meaning instruction width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  branch taken; discard all buffered instructions.
REQ-006 SHALL have port in_instr1  input  IW  older instruction from fetch.
REQ-007 SHALL have port in_instr2  input  IW  younger instruction from fetch.
REQ-008 SHALL have port in_count  input  2  number of valid fetch instructions (0, 1 or 2); 3 is treated as 2.
REQ-009 SHALL have port stall  output  1  to fetch: the buffer cannot accept 2 instructions.
REQ-010 SHALL have port issue_ready  input  1  downstream accepts the presented instructions this cycle.
REQ-011 SHALL have port out_instr1  output  IW  oldest buffered instruction.
REQ-012 SHALL have port out_instr2  output  IW  second-oldest buffered instruction.
REQ-013 SHALL have port out_valid1  output  1  out_instr1 is valid.
REQ-014 SHALL have port out_valid2  output  1  out_instr2 is valid and may be dual-issued.
REQ-015 SHALL have port issingleinstr  output  1  to fetch: single-issue this cycle (out_valid1=1, out_valid2=0).

Function
REQ-016 SHALL implement a circular FIFO with head pointer, tail pointer and occupancy count (0..DEPTH); pointers wrap modulo DEPTH.
REQ-017 SHALL compute stall = (DEPTH - count) < 2 from registered count, so the output is glitch-free.
REQ-018 SHALL push min(in_count,2) entries at tail, instr1 before instr2, when stall=0 and flush=0; inputs are ignored while stall=1.
REQ-019 SHALL drive out_instr1/out_instr2 combinationally from entries head and head+1 (mod DEPTH), with zero-latency presentation.
REQ-020 SHALL decode fields: opcode [15:12], rd [11:9], rs1 [8:6], rs2 [5:3].
REQ-021 SHALL flag pair hazard when entry1.rs1==entry0.rd, or entry1.rs2==entry0.rd, or entry0.opcode[3:2]==2'b11 (branch class issues alone).
REQ-022 SHALL drive out_valid1 = (count>=1) and out_valid2 = (count>=2) & !hazard.
REQ-023 SHALL drive issingleinstr = out_valid1 & !out_valid2.
REQ-024 SHALL pop (out_valid1 + out_valid2) entries when issue_ready=1, and none otherwise.
REQ-025 SHALL update count_next = count + pushed - popped in the same edge when push and pop coincide; pushing into the slots freed by a same-cycle pop is not permitted (stall uses the pre-pop count).
REQ-026 SHALL, on flush=1 at a clock edge, clear head, tail and count to 0 and discard that cycle's push and pop; flush has priority over push/pop.
REQ-027 SHALL make only the outputs change after flush; the outputs read count=0 in the following cycle.
REQ-028 SHALL never overflow (count<=DEPTH) or underflow (count>=0) under any legal input sequence.

Reset
REQ-029 SHALL, on reset=1, immediately set head=0, tail=0 and count=0, giving out_valid1=0, out_valid2=0, issingleinstr=0 and stall=0; storage contents need not be reset.
REQ-030 SHALL, when reset is asserted mid-operation, drop all entries and resume at the first rising edge after reset is released.

Verification
REQ-031 SHALL cover reset then a push of 0x1234 and 0x2345 (in_count=2, issue_ready=0) -> next cycle out_valid1=1, out_valid2=1, out_instr1=0x1234, out_instr2=0x2345, issingleinstr=0.
REQ-032 SHALL cover a hazard pair of 0x1200 (rd=1) and 0x2040 (rs1=1) with issue_ready=1 -> issingleinstr=1, only 0x1200 popped, 0x2040 presented alone the next cycle.
REQ-033 SHALL cover continuous push with issue_ready=0, DEPTH=8 -> stall=1 once count=7, count holds at 7 and later input is ignored; a single pop frees a slot, stall remains 1 until count<=6.
REQ-034 SHALL cover flush asserted together with in_count=2 and issue_ready=1 at count=5 -> next cycle count=0, out_valid1=0, stall=0.
REQ-035 SHALL cover a wrap-around run of 20 instructions with pushes and pops interleaved -> output order identical to input order and no entry lost or duplicated.
REQ-036 SHALL cover reset asserted asynchronously mid-cycle with count=4 -> out_valid1 falls before the next clock edge.
